vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised, registered VGA test-pattern generator.
- Replaces the fixed 6-bit threshold colour logic in the top level.
- Sits between the sync generator (x/y, active, sync, pixel strobe) and the colour pins.
- Provides BPC bits per channel, four selectable patterns (one animated), and sync outputs delayed to stay aligned with colour.

Parameters:
- BPC, 2: bits per colour channel (1..4).
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- CHECK_LOG2, 5: checker square size = 2^CHECK_LOG2 px.
- BOX_SIZE, 32: bouncing box edge length in px.
- SYNC_POL, 0: sync asserted level (0 = active-low).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- px_en  in  1  pixel strobe; all state advances only when high
- x_px  in  10  current pixel column
- y_px  in  10  current pixel row
- active_in  in  1  visible-region flag
- hsync_in  in  1  horizontal sync from sync generator
- vsync_in  in  1  vertical sync from sync generator
- mode_next  in  1  single-clk request to advance pattern mode
- r  out  BPC  red
- g  out  BPC  green
- b  out  BPC  blue
- hsync  out  1  hsync delayed to match colour
- vsync  out  1  vsync delayed to match colour
- mode  out  2  current pattern mode

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values:
  - r/g/b = 0, mode = 0.
  - hsync/vsync = deasserted level (!SYNC_POL).
  - Internal: pending = 0, frame_cnt (8 bit) = 0, box at (0,0) with direction +x +y, pipeline valid/active flags = 0.
- Reset mid-frame: outputs take reset values on the next clk and the pipeline is flushed. Operation resumes on the next px_en after reset deasserts.
- Pipeline:
  - Two px_en-qualified stages: stage 1 registers the inputs, stage 2 registers the colour.
  - Outputs reflect inputs from exactly 2 px_en strobes earlier.
  - hsync, vsync and active are delayed identically.
  - With px_en low, every register holds its value.
- Blanking: when delayed active = 0, r/g/b = 0 regardless of mode.
- Frame start:
  - Condition: px_en high and vsync_in transitions from deasserted to asserted level (previous value kept in a register).
  - Actions: frame_cnt increments (wraps at 255); a pending mode request is applied; the box steps.
- Mode request:
  - A mode_next pulse sets pending.
  - At frame start, if pending, mode = (mode+1) mod 4 and pending clears.
  - Multiple pulses within one frame advance mode by one step only.
  - A pulse in the same clk as frame start is applied at that frame start.
  - Mode never changes mid-frame.
- FS = all-ones of BPC width.
- Mode 0, quantised gradients:
  - g = count of thresholds k*H_ACTIVE/2^BPC (k = 1..2^BPC-1) that x_px exceeds.
  - r = the same rule with y_px against V_ACTIVE.
  - b = the same rule with (x_px+y_px) against H_ACTIVE+V_ACTIVE.
  - All thresholds are elaboration-time constants.
- Mode 1, eight vertical bars:
  - Bar i = x_px / (H_ACTIVE/8), via constant thresholds.
  - r = FS if i[2] else 0; g = FS if i[1] else 0; b = FS if i[0] else 0.
  - Resulting order: black .. white.
- Mode 2, checker:
  - If bit CHECK_LOG2 of x_px XOR the same bit of y_px is 1, then r = g = b = FS; otherwise all 0.
- Mode 3, bouncing box:
  - Inside box (box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE): r = frame_cnt[7 -: BPC], g = FS, b = ~frame_cnt[7 -: BPC].
  - Outside box: r = g = b = 1.
- Box step per frame start, with X limit H_ACTIVE-BOX_SIZE and Y limit V_ACTIVE-BOX_SIZE, applied independently per axis:
  - Moving + and at the limit: reverse and move -1.
  - Moving - and at 0: reverse and move +1.
  - Otherwise: move ±1.
  - The box never leaves the active area.
- The box updates in all modes, so mode 3 resumes from the current position.

Optional Feature:
- Macro: PATTERN_SCROLL_EN.
- Defined:
  - Adds a 10-bit scroll register, reset 0, incremented at each frame start and wrapping H_ACTIVE-1 -> 0.
  - Modes 1 and 2 use xs = x_px + scroll, minus H_ACTIVE if >= H_ACTIVE, in place of x_px, so the pattern scrolls left 1 px per frame.
  - Modes 0 and 3 are unaffected.
- Undefined: no scroll register; xs = x_px.

Test Plan:
- Latency: reset, mode 0, px_en every clk, x=639, y=479, active=1 -> 2 strobes later r = g = b = 3 (BPC=2). With active=0 -> rgb = 0. hsync/vsync match the input delayed by 2 strobes.
- px_en gating: px_en low for 5 clks mid-line with inputs changing -> outputs and sync unchanged; they resume with correct 2-strobe alignment.
- Mode sequencing: three mode_next pulses in one frame -> mode stays 0 until the next vsync edge, then 1. A pulse coincident with frame start -> mode steps at that edge. Four frames, each with one pulse -> mode wraps 3 -> 0.
- Bars: mode 1, x = 0, 80, 560 -> rgb = (0,0,0), (0,0,3), (3,3,3). Checker: mode 2, (x,y) = (0,0) -> 0; (32,0) -> 3; (32,32) -> 0.
- Box bounce: mode 3, 608 frames -> box_x = 608, direction +x. Next frame -> box_x = 607, direction -x. Box_y similarly reverses at 448. Pixel (box_x,box_y) has g = 3; pixel (box_x+32,box_y) is rgb = 1.
- Reset mid-frame: assert reset while mode 3 and box at (100,100) -> next clk rgb = 0, sync deasserted, mode = 0, box (0,0). With PATTERN_SCROLL_EN: after 80 frames in mode 1, pixel x=0 shows bar 1 (b = 3, r = g = 0) and scroll = 80.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: registered VGA test patterns (gradient, bars, checker, bouncing box).
// Define PATTERN_SCROLL_EN to scroll bars/checker left one pixel per frame.
module vga_pattern_gen #(
   parameter int BPC        = 2,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int CHECK_LOG2 = 5,
   parameter int BOX_SIZE   = 32,
   parameter bit SYNC_POL   = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           px_en,
   input  logic [9:0]     x_px,
   input  logic [9:0]     y_px,
   input  logic           active_in,
   input  logic           hsync_in,
   input  logic           vsync_in,
   input  logic           mode_next,
   output logic [BPC-1:0] r,
   output logic [BPC-1:0] g,
   output logic [BPC-1:0] b,
   output logic           hsync,
   output logic           vsync,
   output logic [1:0]     mode
);
   localparam logic [BPC-1:0] FS = '1;
   localparam int XL = H_ACTIVE - BOX_SIZE;
   localparam int YL = V_ACTIVE - BOX_SIZE;
   logic [9:0] x1, y1, xs, box_x, box_y;
   logic act1, hs1, vs1, val1, vs_prev, pending, dir_x, dir_y, fs_evt, in_box, chk;
   logic [7:0] frame_cnt;
   logic [2:0] bar;
   logic [BPC-1:0] gx, gy, gxy, fr, cr, cg, cb;
   assign fs_evt = px_en && (vsync_in == SYNC_POL) && (vs_prev != SYNC_POL);
`ifdef PATTERN_SCROLL_EN
   logic [9:0] scroll;
   logic [10:0] xsum;
   assign xsum = {1'b0, x1} + {1'b0, scroll};
   assign xs = (xsum >= 11'(H_ACTIVE)) ? 10'(xsum - 11'(H_ACTIVE)) : xsum[9:0];
   always_ff @(posedge clk)
      if (reset)
         scroll <= '0;
      else if (fs_evt)
         scroll <= (scroll == 10'(H_ACTIVE - 1)) ? '0 : scroll + 10'd1;
`else
   assign xs = x1;
`endif
   // Thresholds are constants per k; the loops unroll into comparator banks.
   always_comb begin
      gx = '0;
      gy = '0;
      gxy = '0;
      bar = '0;
      for (int k = 1; k < 2**BPC; k++) begin
         if (int'(x1) > k * H_ACTIVE / (2**BPC)) gx = gx + BPC'(1);
         if (int'(y1) > k * V_ACTIVE / (2**BPC)) gy = gy + BPC'(1);
         if (int'(x1) + int'(y1) > k * (H_ACTIVE + V_ACTIVE) / (2**BPC)) gxy = gxy + BPC'(1);
      end
      for (int k = 1; k < 8; k++)
         if (int'(xs) >= k * (H_ACTIVE / 8)) bar = bar + 3'd1;
   end
   assign in_box = ({1'b0, x1} >= {1'b0, box_x}) && ({1'b0, x1} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                   ({1'b0, y1} >= {1'b0, box_y}) && ({1'b0, y1} < {1'b0, box_y} + 11'(BOX_SIZE));
   assign chk = xs[CHECK_LOG2] ^ y1[CHECK_LOG2];
   assign fr = frame_cnt[7 -: BPC];
   always_comb begin
      cr = (mode == 2'd0) ? gy  : (mode == 2'd1) ? {BPC{bar[2]}} : (mode == 2'd2) ? {BPC{chk}} : in_box ? fr  : BPC'(1);
      cg = (mode == 2'd0) ? gx  : (mode == 2'd1) ? {BPC{bar[1]}} : (mode == 2'd2) ? {BPC{chk}} : in_box ? FS  : BPC'(1);
      cb = (mode == 2'd0) ? gxy : (mode == 2'd1) ? {BPC{bar[0]}} : (mode == 2'd2) ? {BPC{chk}} : in_box ? ~fr : BPC'(1);
   end
   always_ff @(posedge clk)
      if (reset) begin
         x1 <= '0;
         y1 <= '0;
         act1 <= 1'b0;
         hs1 <= !SYNC_POL;
         vs1 <= !SYNC_POL;
         val1 <= 1'b0;
         vs_prev <= !SYNC_POL;
         r <= '0;
         g <= '0;
         b <= '0;
         hsync <= !SYNC_POL;
         vsync <= !SYNC_POL;
         mode <= '0;
         pending <= 1'b0;
         frame_cnt <= '0;
         box_x <= '0;
         box_y <= '0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else begin
         if (px_en) begin
            x1 <= x_px;
            y1 <= y_px;
            act1 <= active_in;
            hs1 <= hsync_in;
            vs1 <= vsync_in;
            val1 <= 1'b1;
            vs_prev <= vsync_in;
            r <= (val1 && act1) ? cr : '0;
            g <= (val1 && act1) ? cg : '0;
            b <= (val1 && act1) ? cb : '0;
            hsync <= hs1;
            vsync <= vs1;
         end
         // A request landing on the frame-start clock is honoured immediately.
         if (fs_evt) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (pending || mode_next) mode <= mode + 2'd1;
            pending <= 1'b0;
            if (dir_x && box_x == 10'(XL)) begin
               dir_x <= 1'b0;
               box_x <= box_x - 10'd1;
            end else if (!dir_x && box_x == '0) begin
               dir_x <= 1'b1;
               box_x <= box_x + 10'd1;
            end else
               box_x <= dir_x ? box_x + 10'd1 : box_x - 10'd1;
            if (dir_y && box_y == 10'(YL)) begin
               dir_y <= 1'b0;
               box_y <= box_y - 10'd1;
            end else if (!dir_y && box_y == '0) begin
               dir_y <= 1'b1;
               box_y <= box_y + 10'd1;
            end else
               box_y <= dir_y ? box_y + 10'd1 : box_y - 10'd1;
         end else if (mode_next)
            pending <= 1'b1;
      end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed vector bench for vga_pattern_gen (default parameters).
module tb_vga_pattern_gen;
   localparam int BPC = 2;
   logic clk = 1'b0, reset = 1'b1, px_en = 1'b0, active_in = 1'b0;
   logic hsync_in = 1'b1, vsync_in = 1'b1, mode_next = 1'b0;
   logic [9:0] x_px = '0, y_px = '0;
   logic [BPC-1:0] r, g, b;
   logic hsync, vsync;
   logic [1:0] mode;
   int n_cmp = 0, n_bad = 0, nframes = 0;
   logic [1:0] exp_mode = '0;
   typedef struct {int m; int x; int y; logic a; int r; int g; int b;} vec_t;
   vec_t vt[18];

   always #5 clk = ~clk;

   vga_pattern_gen dut (
      .clk(clk), .reset(reset), .px_en(px_en), .x_px(x_px), .y_px(y_px),
      .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .mode_next(mode_next), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .mode(mode)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rgb(input string nm, input int er, input int eg, input int eb);
      chk({nm, "_r"}, int'(r), er);
      chk({nm, "_g"}, int'(g), eg);
      chk({nm, "_b"}, int'(b), eb);
   endtask

   task automatic step(input int x, input int y, input logic a, input logic hs, input logic vs, input logic pe);
      x_px = 10'(x);
      y_px = 10'(y);
      active_in = a;
      hsync_in = hs;
      vsync_in = vs;
      px_en = pe;
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      nframes++;
   endtask

   task automatic pulse();
      mode_next = 1'b1;
      @(posedge clk);
      #1;
      mode_next = 1'b0;
   endtask

   task automatic adv_mode();
      pulse();
      frame();
      exp_mode = exp_mode + 2'd1;
   endtask

   task automatic set_mode(input int m);
      for (int k = 0; k < 4 && exp_mode != 2'(m); k++) adv_mode();
   endtask

   // Box position after n steps on a 0..l bounce is a triangle wave.
   function automatic int tri_pos(input int n, input int l);
      int m;
      m = n % (2 * l);
      return (m <= l) ? m : 2 * l - m;
   endfunction

   // Compensates the scroll offset so tabulated x values land on the pattern unshifted.
   function automatic int sx(input int x, input bit sc);
`ifdef PATTERN_SCROLL_EN
      return sc ? (x + 640 - nframes % 640) % 640 : x;
`else
      return sc ? x : x;
`endif
   endfunction

   task automatic pix(input int x, input int y, input logic a, input bit sc);
      step(sx(x, sc), y, a, 1'b1, 1'b1, 1'b1);
      step(sx(x, sc), y, a, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      int fr;
      vt[0]  = '{0, 639, 479, 1'b1, 3, 3, 3};
      vt[1]  = '{0,   0,   0, 1'b1, 0, 0, 0};
      vt[2]  = '{0, 161,   0, 1'b1, 0, 1, 0};
      vt[3]  = '{0, 320, 240, 1'b1, 1, 1, 1};
      vt[4]  = '{0, 321, 241, 1'b1, 2, 2, 2};
      vt[5]  = '{0, 500, 100, 1'b1, 0, 3, 2};
      vt[6]  = '{0, 639, 479, 1'b0, 0, 0, 0};
      vt[7]  = '{1,   0,   0, 1'b1, 0, 0, 0};
      vt[8]  = '{1,  79,   0, 1'b1, 0, 0, 0};
      vt[9]  = '{1,  80,   0, 1'b1, 0, 0, 3};
      vt[10] = '{1, 160,   0, 1'b1, 0, 3, 0};
      vt[11] = '{1, 400,   0, 1'b1, 3, 0, 3};
      vt[12] = '{1, 560,   0, 1'b1, 3, 3, 3};
      vt[13] = '{2,   0,   0, 1'b1, 0, 0, 0};
      vt[14] = '{2,  32,   0, 1'b1, 3, 3, 3};
      vt[15] = '{2,  32,  32, 1'b1, 0, 0, 0};
      vt[16] = '{2,  31,  32, 1'b1, 3, 3, 3};
      vt[17] = '{2,  64,   0, 1'b0, 0, 0, 0};

      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_rgb("reset", 0, 0, 0);
      chk("reset_hsync", int'(hsync), 1);
      chk("reset_vsync", int'(vsync), 1);
      chk("reset_mode", int'(mode), 0);
      reset = 1'b0;

      // Two-strobe latency and blanking
      step(639, 479, 1'b1, 1'b0, 1'b1, 1'b1);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk_rgb("lat_a", 3, 3, 3);
      chk("lat_a_hsync", int'(hsync), 0);
      step(639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_rgb("lat_blank", 0, 0, 0);
      chk("lat_b_hsync", int'(hsync), 1);

      // px_en gating
      for (int i = 0; i < 5; i++) step(5 * i, 7 * i, 1'b1, i[0], 1'b1, 1'b0);
      chk_rgb("gate_hold", 0, 0, 0);
      chk("gate_hold_hsync", int'(hsync), 1);
      step(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_rgb("gate_resume", 3, 3, 3);
      chk("gate_resume_hsync", int'(hsync), 1);
      step(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk_rgb("gate_next", 0, 0, 0);
      chk("gate_next_hsync", int'(hsync), 0);

      // Several requests within one frame advance a single step, at the vsync edge
      pulse();
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      pulse();
      pulse();
      chk("mode_midframe", int'(mode), 0);
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("mode_fs", int'(mode), 1);
      chk("vsync_delay_a", int'(vsync), 1);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("vsync_delay_b", int'(vsync), 0);
      nframes++;
      exp_mode = 2'd1;
      mode_next = 1'b1;
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      mode_next = 1'b0;
      chk("mode_coincident", int'(mode), 2);
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
      nframes++;
      exp_mode = 2'd2;
      for (int k = 0; k < 4; k++) begin
         adv_mode();
         chk("mode_wrap", int'(mode), int'(exp_mode));
      end

      for (int i = 0; i < 18; i++) begin
         set_mode(vt[i].m);
         pix(vt[i].x, vt[i].y, vt[i].a, vt[i].m == 1 || vt[i].m == 2);
         chk_rgb($sformatf("vec%0d", i), vt[i].r, vt[i].g, vt[i].b);
      end

      // Bouncing box
      set_mode(3);
      for (int k = 0; k < 700 && nframes < 448; k++) frame();
      chk("box_y_448", int'(dut.box_y), 448);
      chk("dir_y_448", int'(dut.dir_y), 1);
      chk("box_x_448", int'(dut.box_x), tri_pos(448, 608));
      fr = (nframes % 256) >> 6;
      pix(448, 448, 1'b1, 1'b0);
      chk_rgb("box_in_448", fr, 3, 3 - fr);
      frame();
      chk("box_y_449", int'(dut.box_y), 447);
      chk("dir_y_449", int'(dut.dir_y), 0);
      for (int k = 0; k < 700 && nframes < 608; k++) frame();
      chk("box_x_608", int'(dut.box_x), 608);
      chk("dir_x_608", int'(dut.dir_x), 1);
      chk("box_y_608", int'(dut.box_y), tri_pos(608, 448));
      fr = (nframes % 256) >> 6;
      pix(608, 288, 1'b1, 1'b0);
      chk_rgb("box_in_608", fr, 3, 3 - fr);
      pix(640, 288, 1'b1, 1'b0);
      chk_rgb("box_right", 1, 1, 1);
      pix(607, 288, 1'b1, 1'b0);
      chk_rgb("box_left", 1, 1, 1);
      pix(608, 320, 1'b1, 1'b0);
      chk_rgb("box_below", 1, 1, 1);
      frame();
      chk("box_x_609", int'(dut.box_x), 607);
      chk("dir_x_609", int'(dut.dir_x), 0);

      // Reset mid-frame with the box lit and hsync asserted
      step(607, 289, 1'b1, 1'b0, 1'b1, 1'b1);
      step(607, 289, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("pre_reset_g", int'(g), 3);
      reset = 1'b1;
      step(607, 289, 1'b1, 1'b0, 1'b1, 1'b1);
      chk_rgb("midreset", 0, 0, 0);
      chk("midreset_hsync", int'(hsync), 1);
      chk("midreset_vsync", int'(vsync), 1);
      chk("midreset_mode", int'(mode), 0);
      chk("midreset_box_x", int'(dut.box_x), 0);
      chk("midreset_box_y", int'(dut.box_y), 0);
      reset = 1'b0;
      nframes = 0;
      exp_mode = '0;
      pix(639, 479, 1'b1, 1'b0);
      chk_rgb("post_reset", 3, 3, 3);

`ifdef PATTERN_SCROLL_EN
      adv_mode();
      for (int k = 0; k < 100 && nframes < 80; k++) frame();
      chk("scroll_80", int'(dut.scroll), 80);
      pix(0, 0, 1'b1, 1'b0);
      chk_rgb("scroll_bar", 0, 0, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
